vita49_trig_sched: RTL
======================

VITA49_TRIG_SCHED -- requirements
Module: vita49_trig_sched

Interface
REQ-001 SHALL have parameter C_AXIS_TDATA_NUM_BYTES, default 4, stream byte width.
REQ-002 SHALL have parameter C_WIN_DEPTH_LOG2, default 3, log2 of the window-queue depth (depth 8).
REQ-003 SHALL have parameter C_DROP_CLOSED, default 0: 0 = backpressure when the gate is closed; 1 = accept and discard when closed.
REQ-004 SHALL have AXIS_ACLK  in  1  sole clock.
REQ-005 SHALL have AXIS_ARESET  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have S_AXIS_TDATA/TSTRB/TLAST/TVALID  in, and S_AXIS_TREADY  out; widths 8*NB/NB/1/1/1; input stream.
REQ-007 SHALL have M_AXIS_TDATA/TSTRB/TLAST/TVALID  out, and M_AXIS_TREADY  in; same widths; output stream.
REQ-008 SHALL have ctrl  in  32: bit0 en, bit1 flush, bit2 passthrough.
REQ-009 SHALL have win_tsi_on and win_tsi_off  in  32, win_tsf_on and win_tsf_off  in  64; window to enqueue.
REQ-010 SHALL have win_push  in  1  single-cycle enqueue strobe.
REQ-011 SHALL have tsi  in  32 and tsf  in  64; current time from the timing unit.
REQ-012 SHALL have trig  out  1  gate-open indicator.
REQ-013 SHALL have status  out  32: [0] empty, [1] full, [2] overflow sticky, [3] bad_win sticky, [5:4] state, [15:8] fill count, [31:16] missed-window count.
REQ-014 SHALL have drop_cnt  out  32  beats discarded while closed; saturating; counts only when C_DROP_CLOSED=1.

Function
REQ-015 SHALL register ctrl, the window inputs and win_push once, and SHALL register tsi/tsf twice before comparison.
REQ-016 SHALL compare the 96-bit values {tsi,tsf}, unsigned; "reached" means now >= target; each compare result SHALL be registered.
REQ-017 SHALL enqueue the window into a FIFO on win_push when not full; a push while full SHALL be dropped and SHALL set overflow.
REQ-018 SHALL discard at enqueue any window with off <= on, SHALL set bad_win for it, and SHALL NOT store it.
REQ-019 SHALL implement states IDLE=0, ARMED=1, OPEN=2.
REQ-020 SHALL transition IDLE->ARMED when en=1 and the FIFO is not empty; the head entry is loaded into the compare registers.
REQ-021 SHALL transition ARMED->OPEN when on is reached; if off is also reached in the same cycle, it SHALL instead pop the entry, increment the missed count, and remain in ARMED or IDLE.
REQ-022 SHALL transition OPEN->ARMED when off is reached and the FIFO is not empty after the pop, or OPEN->IDLE when it is empty; each pop SHALL free one FIFO slot.
REQ-023 SHALL hold the state machine when en=0; trig SHALL keep its value.
REQ-024 SHALL drive trig=1 only in OPEN or when passthrough=1; trig SHALL be a registered output.
REQ-025 SHALL make trig follow a timestamp crossing 4 clock edges after tsi/tsf present that time.
REQ-026 SHALL, when the gate is open, drive M_AXIS_TVALID = S_AXIS_TVALID and S_AXIS_TREADY = M_AXIS_TREADY, with data, strobe and last passed through combinationally.
REQ-027 SHALL, when the gate is closed, drive M_AXIS_TVALID=0 and S_AXIS_TREADY = C_DROP_CLOSED.
REQ-028 SHALL make a simultaneous push and pop leave the fill count unchanged.
REQ-029 SHALL saturate the missed-window count at 16'hFFFF and drop_cnt at 32'hFFFFFFFF.
REQ-030 SHALL treat flush as synchronous: empty the FIFO, go to IDLE, clear trig and clear the sticky bits and both counters; flush SHALL take priority over push.

Reset
REQ-031 SHALL, on AXIS_ARESET, clear the FIFO and go to IDLE, with trig=0, status=0 except empty=1, and drop_cnt=0.
REQ-032 SHALL gate the stream closed while in reset; a reset in mid-packet truncates the packet and no recovery beat is generated.

Configuration
REQ-033 SHALL, with VITA49_TRIG_PKT_ALIGN_EN defined, defer gate open/close transitions while a packet is in progress; in_pkt is set on an accepted non-last beat and cleared on an accepted TLAST beat.
REQ-034 SHALL, with VITA49_TRIG_PKT_ALIGN_EN defined, let trig change only when in_pkt=0; the state still advances and the pending gate value is applied at the packet boundary.
REQ-035 SHALL, without VITA49_TRIG_PKT_ALIGN_EN, apply gate changes immediately, as in REQ-025.

Verification
REQ-036 SHALL cover: push window on=(10,0) off=(12,0), en=1, sweep tsi 9..13 -> trig rises 4 edges after tsi=10 and falls 4 edges after tsi=12; status returns to IDLE with empty=1.
REQ-037 SHALL cover: push 9 windows into depth 8 -> full=1, overflow=1, fill=8.
REQ-038 SHALL cover: push on=(5,0) off=(6,0) while tsi=7 -> window is popped unopened, missed=1, trig stays 0.
REQ-039 SHALL cover: push on=(5,0) off=(5,0) -> bad_win=1, fill=0.
REQ-040 SHALL cover: C_DROP_CLOSED=1, gate closed, 20 beats -> S_AXIS_TREADY=1, no M_AXIS_TVALID, drop_cnt=20.
REQ-041 SHALL cover: with VITA49_TRIG_PKT_ALIGN_EN, off time reached at beat 3 of an 8-beat packet -> trig falls only after the TLAST beat is accepted.

Source files
------------

// File: rtl/vita49_trig_sched.sv
// Time-scheduled AXI-Stream gate: a FIFO of {on,off} windows opens/closes the stream against VITA-49 time.
// Optional VITA49_TRIG_PKT_ALIGN_EN defers gate changes to packet boundaries.
module vita49_trig_sched #(
  parameter int C_AXIS_TDATA_NUM_BYTES = 4,
  parameter int C_WIN_DEPTH_LOG2       = 3,
  parameter int C_DROP_CLOSED          = 0
) (
  input  logic                                AXIS_ACLK,
  input  logic                                AXIS_ARESET,
  input  logic [8*C_AXIS_TDATA_NUM_BYTES-1:0] S_AXIS_TDATA,
  input  logic [C_AXIS_TDATA_NUM_BYTES-1:0]   S_AXIS_TSTRB,
  input  logic                                S_AXIS_TLAST,
  input  logic                                S_AXIS_TVALID,
  output logic                                S_AXIS_TREADY,
  output logic [8*C_AXIS_TDATA_NUM_BYTES-1:0] M_AXIS_TDATA,
  output logic [C_AXIS_TDATA_NUM_BYTES-1:0]   M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  output logic                                M_AXIS_TVALID,
  input  logic                                M_AXIS_TREADY,
  input  logic [31:0]                         ctrl,
  input  logic [31:0]                         win_tsi_on,
  input  logic [31:0]                         win_tsi_off,
  input  logic [63:0]                         win_tsf_on,
  input  logic [63:0]                         win_tsf_off,
  input  logic                                win_push,
  input  logic [31:0]                         tsi,
  input  logic [63:0]                         tsf,
  output logic                                trig,
  output logic [31:0]                         status,
  output logic [31:0]                         drop_cnt
);
  localparam int   AW     = C_WIN_DEPTH_LOG2;
  localparam int   DEPTH  = 1 << AW;
  localparam logic C_DROP = (C_DROP_CLOSED != 0);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_OPEN = 2'd2} state_t;

  logic [2:0]    r_ctrl;
  logic          r_win_vld_p0;
  logic [95:0]   r_won_p0, r_woff_p0;
  logic [95:0]   r_now_p0, r_now_p1;
  logic [95:0]   r_mem_on  [DEPTH];
  logic [95:0]   r_mem_off [DEPTH];
  logic [95:0]   r_cmp_on, r_cmp_off;
  logic          r_on_rch, r_off_rch, r_rch_stale;
  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [AW:0]   r_count;
  state_t        r_state;
  logic          r_trig, r_ovf, r_bad;
  logic [15:0]   r_missed;
  logic [31:0]   r_drop;

  logic          w_en, w_flush, w_pt, w_full, w_empty, w_bad, w_push_ok;
  logic          w_pop, w_miss, w_load, w_acc, w_drop_inc, w_gate_nxt, w_trig_upd;
  logic [AW-1:0] w_ld_ptr;
  state_t        w_state_nxt;
  logic          w_unused;

  assign w_unused   = &{1'b0, ctrl[31:3], 1'b0};
  assign w_en       = r_ctrl[0];
  assign w_flush    = r_ctrl[1];
  assign w_pt       = r_ctrl[2];
  assign w_full     = (r_count == (AW+1)'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_bad      = (r_woff_p0 <= r_won_p0);
  assign w_push_ok  = r_win_vld_p0 && !w_bad && !w_full && !w_flush;
  assign w_ld_ptr   = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;

  // Stream gate: data path is pure wiring, only the handshake is gated by trig.
  assign M_AXIS_TDATA  = S_AXIS_TDATA;
  assign M_AXIS_TSTRB  = S_AXIS_TSTRB;
  assign M_AXIS_TLAST  = S_AXIS_TLAST;
  assign M_AXIS_TVALID = r_trig & S_AXIS_TVALID;
  assign S_AXIS_TREADY = r_trig ? M_AXIS_TREADY : C_DROP;
  assign w_acc         = S_AXIS_TVALID & S_AXIS_TREADY;
  assign w_drop_inc    = C_DROP && !r_trig && w_acc;

  assign trig     = r_trig;
  assign drop_cnt = r_drop;
  assign status   = {r_missed, 8'(r_count), 2'b00, r_state, r_bad, r_ovf, w_full, w_empty};

  // Window sequencer; reached flags are ignored for one cycle after the compare registers reload.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_miss      = 1'b0;
    w_load      = 1'b0;
    if (w_en && !w_flush) begin
      case (r_state)
        S_IDLE: if (!w_empty) begin
          w_state_nxt = S_ARMED;
          w_load      = 1'b1;
        end
        S_ARMED: if (!r_rch_stale && r_on_rch) begin
          if (r_off_rch) begin
            w_pop  = 1'b1;
            w_miss = 1'b1;
          end else begin
            w_state_nxt = S_OPEN;
          end
        end
        S_OPEN: if (!r_rch_stale && r_off_rch) w_pop = 1'b1;
        default: w_state_nxt = S_IDLE;
      endcase
      if (w_pop) begin
        if (r_count > (AW+1)'(1)) begin
          w_state_nxt = S_ARMED;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
    end
    w_gate_nxt = (w_state_nxt == S_OPEN) || w_pt;
  end

`ifdef VITA49_TRIG_PKT_ALIGN_EN
  logic r_in_pkt;
  logic w_in_pkt_nxt;
  assign w_in_pkt_nxt = w_acc ? ~S_AXIS_TLAST : r_in_pkt;
  assign w_trig_upd   = ~w_in_pkt_nxt;

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) r_in_pkt <= 1'b0;
    else             r_in_pkt <= w_in_pkt_nxt;
  end
`else
  assign w_trig_upd = 1'b1;
`endif

  // p0: window capture and time; p1: second time stage; p2: registered compares.
  always_ff @(posedge AXIS_ACLK) begin
    r_won_p0  <= {win_tsi_on, win_tsf_on};
    r_woff_p0 <= {win_tsi_off, win_tsf_off};
    r_now_p0  <= {tsi, tsf};
    r_now_p1  <= r_now_p0;
    r_on_rch  <= (r_now_p1 >= r_cmp_on);
    r_off_rch <= (r_now_p1 >= r_cmp_off);
    if (w_push_ok) begin
      r_mem_on[r_wr_ptr]  <= r_won_p0;
      r_mem_off[r_wr_ptr] <= r_woff_p0;
    end
    if (w_load) begin
      r_cmp_on  <= r_mem_on[w_ld_ptr];
      r_cmp_off <= r_mem_off[w_ld_ptr];
    end
  end

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      r_ctrl       <= '0;
      r_win_vld_p0 <= 1'b0;
      r_rch_stale  <= 1'b1;
      r_state      <= S_IDLE;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_trig       <= 1'b0;
      r_ovf        <= 1'b0;
      r_bad        <= 1'b0;
      r_missed     <= '0;
      r_drop       <= '0;
    end else begin
      r_ctrl       <= ctrl[2:0];
      r_win_vld_p0 <= win_push;
      r_rch_stale  <= w_load;
      if (w_flush) begin
        r_state  <= S_IDLE;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
        r_trig   <= 1'b0;
        r_ovf    <= 1'b0;
        r_bad    <= 1'b0;
        r_missed <= '0;
        r_drop   <= '0;
      end else begin
        r_state <= w_state_nxt;
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop);
        if (r_win_vld_p0 && w_bad)           r_bad <= 1'b1;
        if (r_win_vld_p0 && !w_bad && w_full) r_ovf <= 1'b1;
        if (w_miss && r_missed != 16'hFFFF)  r_missed <= r_missed + 16'd1;
        if (w_drop_inc && r_drop != 32'hFFFF_FFFF) r_drop <= r_drop + 32'd1;
        if (w_trig_upd) r_trig <= w_gate_nxt;
      end
    end
  end

endmodule
